// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one external combinational ALU
// Build option: define ALU_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (requester 0 wins).
module alu_arbiter #(
    parameter int SAMPLE_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_sel,
    input  logic       req0_m,
    input  logic       req0_cn,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_sel,
    input  logic       req1_m,
    input  logic       req1_cn,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,

    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [3:0] rsp0_f,
    output logic       rsp0_flag,

    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [3:0] rsp1_f,
    output logic       rsp1_flag,

    output logic [3:0] alu_sel,
    output logic       alu_m,
    output logic       alu_cn,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_f,
    input  logic       alu_abflag,

    output logic       busy
);

    // Out-of-range sample delays fall back to a single-cycle sample window
    localparam int SAMPLE_CYCLES = ((SAMPLE_DELAY >= 1) && (SAMPLE_DELAY <= 3)) ? SAMPLE_DELAY : 1;
    localparam logic [1:0] CNT_LAST = 2'(SAMPLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [3:0] op_sel_q, op_sel_d;
    logic       op_m_q, op_m_d;
    logic       op_cn_q, op_cn_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;

    logic [3:0] res_f_q, res_f_d;
    logic       res_flag_q, res_flag_d;

    logic       gnt_id_q, gnt_id_d;
    logic       rsp0_valid_q, rsp0_valid_d;
    logic       rsp1_valid_q, rsp1_valid_d;
    logic       busy_q, busy_d;

    logic       any_valid;
    logic       pick_id;
    logic       accept;
    logic       rsp_taken;

`ifdef ALU_ARBITER_RR_EN
    logic       last_q, last_d;

    // Round-robin pick: on a tie favour the requester that did not win last time
    always_comb begin
        pick_id = ~req0_valid;
        if (req0_valid && req1_valid) begin
            pick_id = ~last_q;
        end
        last_d = accept ? pick_id : last_q;
    end

    // Last-grant pointer; resets to requester 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority pick: requester 0 wins whenever it is valid
    always_comb begin
        pick_id = ~req0_valid;
    end
`endif

    // Grant is offered only while idle, and never in a cycle whose edge resets the block
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        accept     = (state_q == IDLE) && any_valid && !rst;
        req0_ready = accept && !pick_id;
        req1_ready = accept && pick_id;
        rsp_taken  = gnt_id_q ? rsp1_ready : rsp0_ready;
    end

    // Next-state and datapath: latch on accept, sample ALU after the delay, hold until taken
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_sel_d   = op_sel_q;
        op_m_d     = op_m_q;
        op_cn_d    = op_cn_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_f_d    = res_f_q;
        res_flag_d = res_flag_q;
        gnt_id_d   = gnt_id_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_id_d = pick_id;
                    op_sel_d = pick_id ? req1_sel : req0_sel;
                    op_m_d   = pick_id ? req1_m   : req0_m;
                    op_cn_d  = pick_id ? req1_cn  : req0_cn;
                    op_a_d   = pick_id ? req1_a   : req0_a;
                    op_b_d   = pick_id ? req1_b   : req0_b;
                    cnt_d    = 2'd0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == CNT_LAST) begin
                    res_f_d    = alu_f;
                    res_flag_d = alu_abflag;
                    cnt_d      = 2'd0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                if (rsp_taken) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rsp0_valid_d = (state_d == RESP) && !gnt_id_d;
        rsp1_valid_d = (state_d == RESP) && gnt_id_d;
        busy_d       = (state_d != IDLE);
    end

    // FSM and registered outputs; reset abandons any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            op_sel_q     <= 4'd0;
            op_m_q       <= 1'b0;
            op_cn_q      <= 1'b0;
            op_a_q       <= 4'd0;
            op_b_q       <= 4'd0;
            res_f_q      <= 4'd0;
            res_flag_q   <= 1'b0;
            gnt_id_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_sel_q     <= op_sel_d;
            op_m_q       <= op_m_d;
            op_cn_q      <= op_cn_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            res_f_q      <= res_f_d;
            res_flag_q   <= res_flag_d;
            gnt_id_q     <= gnt_id_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    // The ALU always sees the op register, so it holds the last operation between issues
    assign alu_sel   = op_sel_q;
    assign alu_m     = op_m_q;
    assign alu_cn    = op_cn_q;
    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;

    // One shared result register feeds both responders; only the valids qualify it
    assign rsp0_f    = res_f_q;
    assign rsp0_flag = res_flag_q;
    assign rsp1_f    = res_f_q;
    assign rsp1_flag = res_flag_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign busy       = busy_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter SAMPLE_DELAY, default 1, meaning cycles ALU operands are held stable before result capture (legal 1..3).
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have: req0_valid / req1_valid  in  1 each  requester N presents an operation.
REQ-005 SHALL have: req0_ready / req1_ready  out  1 each  operation accepted this cycle.
REQ-006 SHALL have: reqN_sel  in  4, reqN_m  in  1, reqN_cn  in  1, reqN_a  in  4, reqN_b  in  4  requester N operation fields.
REQ-007 SHALL have: rsp0_valid / rsp1_valid  out  1 each  result available to requester N.
REQ-008 SHALL have: rsp0_ready / rsp1_ready  in  1 each  requester N takes result.
REQ-009 SHALL have: rspN_f  out  4, rspN_flag  out  1  captured result and all-ones flag.
REQ-010 SHALL have: alu_sel  out  4, alu_m  out  1, alu_cn  out  1, alu_a  out  4, alu_b  out  4  drive to shared ALU.
REQ-011 SHALL have: alu_f  in  4, alu_abflag  in  1  combinational ALU outputs.
REQ-012 SHALL have: busy  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, RESP; one operation in flight at a time.
REQ-014 IDLE: if any reqN_valid, SHALL assert exactly one reqN_ready (the grant) combinationally in that cycle, latch granted fields into op register, record grant id, go ISSUE.
REQ-015 reqN_ready SHALL be low in ISSUE and RESP and for the non-granted requester.
REQ-016 ISSUE: alu_* SHALL equal the op register; delay counter (2 bits) SHALL count from 0; after SAMPLE_DELAY cycles in ISSUE, alu_f/alu_abflag SHALL be registered into result register and FSM SHALL go RESP.
REQ-017 Latency: rspN_valid SHALL rise exactly SAMPLE_DELAY+1 cycles after the accept cycle.
REQ-018 RESP: only granted rspN_valid SHALL be high; rspN_f/rspN_flag SHALL hold result; on rspN_ready high, go IDLE next cycle; otherwise hold indefinitely (backpressure).
REQ-019 rspN_f/rspN_flag SHALL be driven for both N from the single result register; only rspN_valid qualifies.
REQ-020 alu_* SHALL hold last issued operation in IDLE and RESP (no glitching to zero).
REQ-021 Request fields SHALL be sampled only on accept; changes after accept SHALL NOT affect the in-flight result.
REQ-022 A new request SHALL NOT be accepted in the cycle RESP completes; earliest next accept is the following IDLE cycle.
REQ-023 SAMPLE_DELAY outside 1..3 SHALL be treated as 1.

Reset
REQ-024 rst high at a clock edge SHALL force IDLE, counter 0, op register 0, result register 0, last-grant pointer to requester 1 (so requester 0 wins first), all outputs 0.
REQ-025 rst mid-ISSUE or mid-RESP SHALL abandon the operation; no rspN_valid SHALL be produced for it.

Configuration
REQ-026 Macro ALU_ARBITER_RR_EN defined: round-robin arbitration; on simultaneous valids, grant the requester not granted last; pointer updates on each accept.
REQ-027 Macro undefined: fixed priority, requester 0 always wins on simultaneous valids; pointer logic absent.

Verification (ALU modelled behaviourally per shared ALU function table)
REQ-028 req0: m=1 sel=14 a=3 b=4, SAMPLE_DELAY=1 -> req0_ready same cycle, rsp0_valid 2 cycles later, rsp0_f=7, rsp0_flag=0.
REQ-029 req1: m=0 sel=1 cn=0 a=3 b=4 -> rsp1_f=8; m=1 sel=12 -> rsp1_f=15, rsp1_flag=1.
REQ-030 Both valid every cycle, RR_EN defined -> grants alternate 0,1,0,1; undefined -> grants 0,0,0,0.
REQ-031 rsp0_ready held low 10 cycles -> rsp0_valid and rsp0_f stable, req ready low, busy high throughout; accept resumes one cycle after rsp0_ready.
REQ-032 rst asserted in ISSUE with SAMPLE_DELAY=3 -> next cycle IDLE, all outputs 0, no rsp_valid for aborted op.
REQ-033 req0 fields changed the cycle after accept -> rsp0_f reflects originally accepted operands.
